store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write-side store queue between the MEM-stage store path and the data memory write port.
- Accepts word-aligned stores with byte enables.
- Drains one store per cycle into data memory whenever the memory port is free.
- Forwards buffered bytes to loads that probe a matching word, so loads never see stale memory data.

Parameters:
DEPTH, 4, number of buffer entries; power of two, 2..16
AW, 32, address width in bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset; 0 clears the buffer immediately
st_valid  in  1  store request from the MEM stage
st_addr  in  AW  store byte address; bits [1:0] ignored
st_data  in  32  store data, already lane-aligned
st_be  in  4  byte enables, bit i = lane i (data bits 8i+7:8i)
st_pc  in  32  PC of the store instruction
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  load probe from the MEM stage
ld_addr  in  AW  load byte address; bits [1:0] ignored
fwd_be  out  4  lanes supplied by the buffer
fwd_data  out  32  forwarded bytes; lanes not in fwd_be are 0
fwd_hit  out  1  OR of fwd_be
dm_ready  in  1  data memory write port free this cycle
dm_we  out  1  write strobe to data memory
dm_addr  out  AW  word address to data memory, bits [1:0] = 0
dm_wdata  out  32  write data
dm_be  out  4  write byte enables
dm_pc  out  32  PC of the draining store
empty  out  1  no valid entries
count  out  clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage is a circular FIFO with head and tail pointers, each clog2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty.
- Each entry holds the word address, data, be and pc.
- Reset (async, reset=0):
  - head, tail and count go to 0 and all entries are invalidated.
  - Outputs: st_ready=1, empty=1, dm_we=0, fwd_hit=0, fwd_be=0, fwd_data=0.
  - A reset mid-drain discards every queued store; no partial write is issued.
- Push:
  - A push occurs when st_valid && st_ready at a rising edge. The entry is written at tail, then tail increments modulo 2*DEPTH.
  - st_ready = !full. There is no same-cycle bypass, so a full buffer rejects the store even if a pop happens in that cycle.
  - A store with st_be=0 is accepted and queued; memory contents are unchanged when it drains.
- Pop:
  - The head entry is presented combinationally on dm_addr, dm_wdata, dm_be and dm_pc.
  - dm_we = !empty && dm_ready. The entry is popped at the edge where dm_we=1.
- Latency: a store pushed at edge N can drain no earlier than edge N+1. The empty buffer is never bypassed.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- Pointers wrap from 2*DEPTH-1 back to 0. Full is asserted when the index bits are equal and the MSBs differ.
- Forwarding (combinational, only when ld_valid=1; all fwd outputs are 0 otherwise):
  - Compare ld_addr[AW-1:2] against every valid entry.
  - For each lane i, take the youngest matching entry with be[i]=1. That entry supplies fwd_data lane i, and fwd_be[i]=1.
  - The entry being popped in this cycle is still eligible.
  - A store being pushed in this cycle is not eligible.
- The consumer merges fwd_data into memory read data by lane. A partial hit (fwd_be not 4'hF) is legal.
- count and empty are registered state, updated on each edge.

Optional Feature:
- Macro: SB_TRACE_EN.
- Defined: on every edge with dm_we=1, print one line `"%d@%h: *%h <= %h"` carrying $time, dm_pc, dm_addr, and dm_wdata masked by dm_be (disabled lanes forced to 0).
  - In this configuration the data memory's own write trace is the redundant one; the checker consumes this trace.
- Undefined: no display statements are compiled in; functional behaviour is identical.

Test Plan:
1. Reset then push addr 0x10, data 0xDEADBEEF, be 0xF, dm_ready=1 → dm_we high one cycle later with dm_addr 0x10, wdata 0xDEADBEEF; empty=1 afterwards.
2. dm_ready=0, push 4 stores → st_ready=0 and count=4; a 5th st_valid is not accepted. Raise dm_ready → drains in push order, one per cycle.
3. Push 0x20/0x11111111/0xF then 0x20/0x0000AA00/0x2 (dm_ready=0); probe ld_addr 0x22 → fwd_be=0xF, fwd_data=0x1111AA11.
4. Only 0x30/be 0xC/0xBBBB0000 buffered; probe 0x30 → fwd_be=0xC, fwd_data=0xBBBB0000, fwd_hit=1. Probe 0x34 → fwd_hit=0.
5. Full buffer, simultaneous st_valid and dm_ready → pop occurs, push rejected (count 4→3). Next cycle push accepted (count back to 4). Run 10 push/pop cycles to exercise pointer wrap without loss.
6. Assert reset=0 asynchronously mid-drain with 3 entries → dm_we and count drop to 0 before the next edge; after release no stale store is written.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: write-side store queue between the MEM-stage store path and
// the data memory write port. Stores drain in order, one per cycle, whenever
// the memory port is free. Loads probing a buffered word get the youngest
// buffered bytes for each lane, so they never see stale memory data.
// Optional feature macro: SB_TRACE_EN prints one line per committed drain.
//
// Handshakes:
//   store side: a store is taken at a rising edge where st_valid && st_ready.
//     st_ready depends only on registered state (not full) and never on the
//     pop in the same cycle.
//   memory side: the head entry is always shown on dm_*; it is written and
//     popped at a rising edge where dm_we (= !empty && dm_ready) is high.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_be,
  input  logic [31:0]              st_pc,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic [3:0]               fwd_be,
  output logic [31:0]              fwd_data,
  output logic                     fwd_hit,
  input  logic                     dm_ready,
  output logic                     dm_we,
  output logic [AW-1:0]            dm_addr,
  output logic [31:0]              dm_wdata,
  output logic [3:0]               dm_be,
  output logic [31:0]              dm_pc,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_count;
  logic          r_empty;
  logic [DEPTH-1:0] r_valid;

  logic [AW-3:0] r_waddr [DEPTH];
  logic [31:0]   r_data  [DEPTH];
  logic [3:0]    r_be    [DEPTH];
  logic [31:0]   r_pc    [DEPTH];

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_head_idx;
  logic [IW-1:0] w_tail_idx;
  logic [PW-1:0] w_count_nxt;
  logic [IW-1:0] w_fwd_idx;
  logic          w_unused;

  assign w_head_idx  = r_head[IW-1:0];
  assign w_tail_idx  = r_tail[IW-1:0];
  assign w_full      = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);
  assign st_ready    = !w_full;
  assign w_push      = st_valid && !w_full;
  assign dm_we       = !r_empty && dm_ready;
  assign w_pop       = dm_we;
  assign w_count_nxt = r_count + PW'(w_push) - PW'(w_pop);

  assign dm_addr  = {r_waddr[w_head_idx], 2'b00};
  assign dm_wdata = r_data[w_head_idx];
  assign dm_be    = r_be[w_head_idx];
  assign dm_pc    = r_pc[w_head_idx];
  assign empty    = r_empty;
  assign count    = r_count;
  assign fwd_hit  = |fwd_be;

  // Byte-offset bits of both addresses are intentionally ignored.
  assign w_unused = &{1'b0, st_addr[1:0], ld_addr[1:0]};

  // Pointer, occupancy and valid-bit state; reset drops every queued store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_tail              <= r_tail + PW'(1);
        r_valid[w_tail_idx] <= 1'b1;
      end
      if (w_pop) begin
        r_head              <= r_head + PW'(1);
        r_valid[w_head_idx] <= 1'b0;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Entry payload write at the tail; contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[w_tail_idx] <= st_addr[AW-1:2];
      r_data[w_tail_idx]  <= st_data;
      r_be[w_tail_idx]    <= st_be;
      r_pc[w_tail_idx]    <= st_pc;
    end
  end

  // Forwarding: walk oldest to youngest so younger matching lanes win.
  always_comb begin
    fwd_be    = '0;
    fwd_data  = '0;
    w_fwd_idx = '0;
    if (ld_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_fwd_idx = w_head_idx + IW'(k);
        if ((PW'(k) < r_count) && r_valid[w_fwd_idx] &&
            (r_waddr[w_fwd_idx] == ld_addr[AW-1:2])) begin
          for (int i = 0; i < 4; i++) begin
            if (r_be[w_fwd_idx][i]) begin
              fwd_be[i]         = 1'b1;
              fwd_data[8*i +: 8] = r_data[w_fwd_idx][8*i +: 8];
            end
          end
        end
      end
    end
  end

`ifdef SB_TRACE_EN
  logic [31:0] w_trace_data;
  assign w_trace_data = dm_wdata & {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}};

  // Emit one line per committed drain, disabled lanes shown as zero.
  always_ff @(posedge clk) begin
    if (dm_we) $display("%d@%h: *%h <= %h", $time, dm_pc, dm_addr, w_trace_data);
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic,
// checked against a queue-level model of the buffer contents.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int EW    = AW + 68;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
    logic [31:0]   pc;
  } st_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic [31:0]   st_pc;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [3:0]    fwd_be;
  logic [31:0]   fwd_data;
  logic          fwd_hit;
  logic          dm_ready;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_be;
  logic [31:0]   dm_pc;
  logic          empty;
  logic [PW-1:0] count;

  st_t            mdl_q[$];
  logic [EW-1:0]  exp_q[$];
  int             n_tests = 0;
  int             n_fail  = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .fwd_be(fwd_be), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
    .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_pc(dm_pc),
    .empty(empty), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference forwarding: scan the buffered stores oldest to youngest.
  function automatic void mdl_fwd(input logic lv, input logic [AW-1:0] a,
                                  output logic [3:0] be, output logic [31:0] d);
    be = '0;
    d  = '0;
    if (lv) begin
      foreach (mdl_q[k]) begin
        if (mdl_q[k].addr[AW-1:2] == a[AW-1:2]) begin
          for (int i = 0; i < 4; i++) begin
            if (mdl_q[k].be[i]) begin
              be[i]        = 1'b1;
              d[8*i +: 8]  = mdl_q[k].data[8*i +: 8];
            end
          end
        end
      end
    end
  endfunction

  // One clock of stimulus: drive, check state/forwarding, then apply the edge.
  task automatic cycle(input logic sv, input logic [AW-1:0] sa, input logic [31:0] sd,
                       input logic [3:0] sbe, input logic [31:0] spc,
                       input logic lv, input logic [AW-1:0] la, input logic dr);
    st_t         e;
    logic        push;
    logic        pop;
    logic [3:0]  ebe;
    logic [31:0] ed;
    int          sz;
    st_valid = sv; st_addr = sa; st_data = sd; st_be = sbe; st_pc = spc;
    ld_valid = lv; ld_addr = la; dm_ready = dr;
    @(negedge clk);
    #1;
    sz = mdl_q.size();
    check("st_ready", st_ready, sz < DEPTH);
    check("count", count, sz);
    check("empty", empty, sz == 0);
    check("dm_we", dm_we, (sz > 0) && dr);
    mdl_fwd(lv, la, ebe, ed);
    check("fwd_be", fwd_be, ebe);
    check("fwd_data", fwd_data, ed);
    check("fwd_hit", fwd_hit, |ebe);
    push = sv && (sz < DEPTH);
    pop  = (sz > 0) && dr;
    e.addr = {sa[AW-1:2], 2'b00};
    e.data = sd;
    e.be   = sbe;
    e.pc   = spc;
    @(posedge clk);
    if (pop) void'(mdl_q.pop_front());
    if (push) begin
      mdl_q.push_back(e);
      exp_q.push_back(e);
    end
    #2;
  endtask

  task automatic idle(input logic dr);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, '0, dr);
  endtask

  // scoreboard monitor: every presented drain must match the oldest expected store
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset && dm_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_unexpected: got drain of %h required none", dm_addr);
      end else begin
        e = exp_q.pop_front();
        check("drain", {dm_addr, dm_wdata, dm_be, dm_pc}, e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    st_valid = 0; st_addr = '0; st_data = '0; st_be = '0; st_pc = '0;
    ld_valid = 0; ld_addr = '0; dm_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", st_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_we", dm_we, 0);
    check("rst_fwd", {fwd_hit, fwd_be, fwd_data}, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // 1: single store drains one cycle after it is pushed
    cycle(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h1000, 0, '0, 1);
    idle(1);
    idle(1);

    // 2: fill with memory busy, fifth store rejected, then ordered drain
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h100 + 4 * i, $urandom, 4'hF, 32'h2000 + i, 0, '0, 0);
    cycle(1, 32'h200, 32'hBAD0BAD0, 4'hF, 32'h2FFF, 0, '0, 0);
    for (int i = 0; i < 5; i++) idle(1);

    // 3: younger partial store overrides one lane of an older full store
    cycle(1, 32'h20, 32'h11111111, 4'hF, 32'h3000, 0, '0, 0);
    cycle(1, 32'h20, 32'h0000AA00, 4'h2, 32'h3004, 0, '0, 0);
    st_valid = 0; ld_valid = 1; ld_addr = 32'h22; #1;
    check("t3_fwd_be", fwd_be, 4'hF);
    check("t3_fwd_data", fwd_data, 32'h1111AA11);
    cycle(0, '0, '0, '0, '0, 1, 32'h22, 0);
    for (int i = 0; i < 3; i++) idle(1);

    // 4: partial hit and miss
    cycle(1, 32'h30, 32'hBBBB0000, 4'hC, 32'h4000, 0, '0, 0);
    st_valid = 0; ld_valid = 1; ld_addr = 32'h30; #1;
    check("t4_hit", {fwd_hit, fwd_be, fwd_data}, {1'b1, 4'hC, 32'hBBBB0000});
    ld_addr = 32'h34; #1;
    check("t4_miss", fwd_hit, 0);
    cycle(0, '0, '0, '0, '0, 1, 32'h30, 0);
    cycle(0, '0, '0, '0, '0, 1, 32'h34, 1);

    // 5: full buffer with simultaneous push and pop, then wrap traffic
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h500 + 4 * i, $urandom, 4'hF, 32'h5000 + i, 0, '0, 0);
    cycle(1, 32'h600, $urandom, 4'hF, 32'h5100, 0, '0, 1);
    cycle(1, 32'h604, $urandom, 4'hF, 32'h5101, 0, '0, 0);
    for (int i = 0; i < 10; i++)
      cycle(1, 32'h700 + 4 * i, $urandom, 4'(i), 32'h5200 + i, 1, 32'h700 + 4 * i, 1);
    for (int i = 0; i < 6; i++) idle(1);

    // 6: asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h800 + 4 * i, $urandom, 4'hF, 32'h6000 + i, 0, '0, 0);
    st_valid = 0; ld_valid = 0; dm_ready = 1; #1;
    check("t6_pre_we", dm_we, 1);
    reset = 1'b0; #1;
    check("t6_rst_we", dm_we, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_ready", st_ready, 1);
    mdl_q.delete();
    exp_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) idle(1);

    // random traffic over a few words to provoke forwarding hits
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) < 60,
            32'h40 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3),
            $urandom, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 1),
            32'h40 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3),
            $urandom_range(0, 99) < 50);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
